// File: rtl/uart_rx_controller.sv
// UART receive sequencer: oversampled start qualification, 11-bit frame capture,
// payload/error registers and a valid/ready handshake with overrun detection.
module uart_rx_controller #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        baud_tick,
  input  logic        rx_serial,
  input  logic        parity_odd,
  input  logic        rx_ready,
  output logic [10:0] data_parll,
  output logic        recieved_flag,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        parity_error,
  output logic        framing_error,
  output logic        overrun,
  output logic        busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    B_STOP = 4'd10;

  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_param
    $error("uart_rx_controller: OVERSAMPLE must be even and >= 4");
  end

  typedef enum logic [1:0] {IDLE, START, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [10:0]   sh_q, sh_d;
  logic [10:0]   data_parll_q, data_parll_d;
  logic          recieved_flag_q, recieved_flag_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          parity_error_q, parity_error_d;
  logic          framing_error_q, framing_error_d;
  logic          overrun_q, overrun_d;
  logic          handshake;

  assign handshake = rx_valid_q & rx_ready;

  always_comb begin
    state_d         = state_q;
    rx_meta_d       = rx_serial;
    rx_s_d          = rx_meta_q;
    tcnt_d          = tcnt_q;
    bcnt_d          = bcnt_q;
    sh_d            = sh_q;
    data_parll_d    = data_parll_q;
    recieved_flag_d = 1'b0;
    rx_data_d       = rx_data_q;
    rx_valid_d      = rx_valid_q;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;
    overrun_d       = overrun_q;

    if (handshake) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (baud_tick && !rx_s_q) begin
          state_d = START;
          tcnt_d  = '0;
        end
      end

      START: begin
        if (baud_tick) begin
          if (tcnt_q == T_MID) begin
            tcnt_d = '0;
            // Line back high at mid start bit is treated as noise.
            if (!rx_s_q) begin
              sh_d[0] = 1'b0;
              bcnt_d  = 4'd1;
              state_d = SHIFT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      SHIFT: begin
        if (baud_tick) begin
          if (tcnt_q == T_LAST) begin
            tcnt_d = '0;
            for (int i = 0; i < 11; i++) begin
              if (bcnt_q == 4'(i)) sh_d[i] = rx_s_q;
            end
            if (bcnt_q == B_STOP) begin
              bcnt_d  = 4'd0;
              state_d = DONE;
            end else begin
              bcnt_d = bcnt_q + 4'd1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        data_parll_d    = sh_q;
        recieved_flag_d = 1'b1;
        rx_data_d       = sh_q[8:1];
        parity_error_d  = (^sh_q[9:1]) ^ parity_odd;
        framing_error_d = ~sh_q[10];
        rx_valid_d      = 1'b1;
        // A handshake landing on this same edge retires the old frame cleanly.
        if (rx_valid_q && !rx_ready) overrun_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      tcnt_q          <= '0;
      bcnt_q          <= 4'd0;
      sh_q            <= 11'h7FE;
      data_parll_q    <= 11'h7FE;
      recieved_flag_q <= 1'b0;
      rx_data_q       <= 8'hFF;
      rx_valid_q      <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      rx_meta_q       <= rx_meta_d;
      rx_s_q          <= rx_s_d;
      tcnt_q          <= tcnt_d;
      bcnt_q          <= bcnt_d;
      sh_q            <= sh_d;
      data_parll_q    <= data_parll_d;
      recieved_flag_q <= recieved_flag_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
    end
  end

  assign data_parll    = data_parll_q;
  assign recieved_flag = recieved_flag_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: directed scenarios plus randomized frames
// checked against a frame-level model of payload, error flags and handshake state.
module tb_uart_rx_controller;

  localparam int OS       = 16;
  localparam int TICK_DIV = 3;
  localparam int GAP      = 24;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        baud_tick = 1'b0;
  logic        rx_serial = 1'b1;
  logic        parity_odd = 1'b0;
  logic        rx_ready = 1'b0;
  logic [10:0] data_parll;
  logic        recieved_flag;
  logic [7:0]  rx_data;
  logic        rx_valid, parity_error, framing_error, overrun, busy;

  uart_rx_controller #(.OVERSAMPLE(OS)) dut (
    .clock(clock), .reset(reset), .baud_tick(baud_tick), .rx_serial(rx_serial),
    .parity_odd(parity_odd), .rx_ready(rx_ready), .data_parll(data_parll),
    .recieved_flag(recieved_flag), .rx_data(rx_data), .rx_valid(rx_valid),
    .parity_error(parity_error), .framing_error(framing_error),
    .overrun(overrun), .busy(busy)
  );

  always #5 clock = ~clock;

  int tick_div_cnt = 0;
  int tick_count = 0;
  always @(posedge clock) begin
    tick_div_cnt <= (tick_div_cnt == TICK_DIV - 1) ? 0 : tick_div_cnt + 1;
    baud_tick    <= (tick_div_cnt == TICK_DIV - 1);
    if (baud_tick) tick_count <= tick_count + 1;
  end

  int   tests = 0;
  int   fails = 0;
  int   pulse_cnt = 0;
  int   wide_pulses = 0;
  logic flag_prev = 1'b0;
  always @(negedge clock) begin
    if (recieved_flag) pulse_cnt++;
    if (recieved_flag && flag_prev) wide_pulses++;
    flag_prev = recieved_flag;
  end

  // Frame-level reference state
  logic        exp_valid = 1'b0, exp_overrun = 1'b0, exp_pe = 1'b0, exp_fe = 1'b0;
  logic [7:0]  exp_data = 8'hFF;
  logic [10:0] exp_parll = 11'h7FE;

  task automatic wait_ticks(input int n);
    int target;
    target = tick_count + n;
    while (tick_count < target) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_serial = f[i];
      wait_ticks(OS);
    end
    rx_serial = 1'b1;
    wait_ticks(GAP);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
    int ones;
    ones = $countones(d) + int'(par);
    exp_parll   = {stop, par, d, 1'b0};
    exp_data    = d;
    exp_pe      = parity_odd ? (ones % 2 == 0) : (ones % 2 == 1);
    exp_fe      = (stop == 1'b0);
    exp_overrun = exp_overrun | exp_valid;
    exp_valid   = 1'b1;
  endtask

  task automatic do_handshake();
    @(negedge clock);
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
    if (exp_valid) begin
      exp_valid   = 1'b0;
      exp_overrun = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    tests++; if (data_parll !== 11'h7FE) begin fails++; $display("FAIL reset_parll got %h want 7fe", data_parll); end
    tests++; if (rx_data !== 8'hFF) begin fails++; $display("FAIL reset_rx_data got %h want ff", rx_data); end
    tests++; if ({recieved_flag, rx_valid, parity_error, framing_error, overrun, busy} !== 6'b0) begin
      fails++; $display("FAIL reset_flags got %b want 000000",
                        {recieved_flag, rx_valid, parity_error, framing_error, overrun, busy});
    end
    exp_valid = 1'b0; exp_overrun = 1'b0;
  endtask

  task automatic test_good_frame();
    int p0;
    parity_odd = 1'b0;
    p0 = pulse_cnt;
    send_frame(8'h55, 1'b0, 1'b1);
    tests++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL good_pulses got %0d want 1", pulse_cnt - p0); end
    tests++; if (data_parll !== 11'h4AA) begin fails++; $display("FAIL good_parll got %h want 4aa", data_parll); end
    tests++; if (rx_data !== 8'h55) begin fails++; $display("FAIL good_rx_data got %h want 55", rx_data); end
    tests++; if ({rx_valid, parity_error, framing_error, overrun} !== 4'b1000) begin
      fails++; $display("FAIL good_flags got %b want 1000", {rx_valid, parity_error, framing_error, overrun});
    end
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL good_ready_clear got %b want 0", rx_valid); end
    exp_valid = 1'b0; exp_overrun = 1'b0;
  endtask

  task automatic test_parity_error();
    parity_odd = 1'b1;
    send_frame(8'h55, 1'b0, 1'b1);
    tests++; if (parity_error !== 1'b1) begin fails++; $display("FAIL odd_par0_pe got %b want 1", parity_error); end
    tests++; if (rx_data !== 8'h55) begin fails++; $display("FAIL odd_par0_data got %h want 55", rx_data); end
    do_handshake();
    send_frame(8'h55, 1'b1, 1'b1);
    tests++; if (parity_error !== 1'b0) begin fails++; $display("FAIL odd_par1_pe got %b want 0", parity_error); end
    do_handshake();
    parity_odd = 1'b0;
  endtask

  task automatic test_framing_error();
    parity_odd = 1'b0;
    send_frame(8'hA3, 1'b0, 1'b0);
    tests++; if (framing_error !== 1'b1) begin fails++; $display("FAIL frame_fe got %b want 1", framing_error); end
    tests++; if (data_parll !== 11'h146) begin fails++; $display("FAIL frame_parll got %h want 146", data_parll); end
    tests++; if (rx_data !== 8'hA3) begin fails++; $display("FAIL frame_data got %h want a3", rx_data); end
    tests++; if (parity_error !== 1'b0) begin fails++; $display("FAIL frame_pe got %b want 0", parity_error); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL frame_idle_busy got %b want 0", busy); end
    do_handshake();
  endtask

  task automatic test_glitch();
    int p0;
    p0 = pulse_cnt;
    rx_serial = 1'b0;
    wait_ticks(OS / 4);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_hi got %b want 1", busy); end
    rx_serial = 1'b1;
    wait_ticks(OS);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_lo got %b want 0", busy); end
    tests++; if (pulse_cnt !== p0 || rx_valid !== 1'b0) begin
      fails++; $display("FAIL glitch_no_frame got pulses %0d valid %b want 0 0", pulse_cnt - p0, rx_valid);
    end
    send_frame(8'h0F, 1'b0, 1'b1);
    tests++; if (data_parll !== 11'h41E || rx_data !== 8'h0F || rx_valid !== 1'b1) begin
      fails++; $display("FAIL glitch_next_frame got %h/%h/%b want 41e/0f/1", data_parll, rx_data, rx_valid);
    end
    do_handshake();
  endtask

  task automatic test_overrun();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    tests++; if ({rx_valid, overrun} !== 2'b10) begin fails++; $display("FAIL ovr_first got %b want 10", {rx_valid, overrun}); end
    send_frame(8'h22, 1'b0, 1'b1);
    tests++; if (rx_data !== 8'h22) begin fails++; $display("FAIL ovr_data got %h want 22", rx_data); end
    tests++; if ({rx_valid, overrun} !== 2'b11) begin fails++; $display("FAIL ovr_set got %b want 11", {rx_valid, overrun}); end
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
    tests++; if ({rx_valid, overrun} !== 2'b00) begin fails++; $display("FAIL ovr_clear got %b want 00", {rx_valid, overrun}); end
    exp_valid = 1'b0; exp_overrun = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int          p0;
    logic [10:0] f;
    f  = {1'b1, 1'b0, 8'h5A, 1'b0};
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      rx_serial = f[i];
      wait_ticks(OS);
    end
    rx_serial = f[5];
    wait_ticks(OS / 2);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clock);
    tests++; if (data_parll !== 11'h7FE || rx_data !== 8'hFF) begin
      fails++; $display("FAIL mid_reset_regs got %h/%h want 7fe/ff", data_parll, rx_data);
    end
    tests++; if ({rx_valid, parity_error, framing_error, overrun, busy} !== 5'b0) begin
      fails++; $display("FAIL mid_reset_flags got %b want 00000",
                        {rx_valid, parity_error, framing_error, overrun, busy});
    end
    reset = 1'b0;
    rx_serial = 1'b1;
    exp_valid = 1'b0; exp_overrun = 1'b0;
    wait_ticks(GAP);
    tests++; if (pulse_cnt !== p0) begin fails++; $display("FAIL mid_no_pulse got %0d want 0", pulse_cnt - p0); end
    send_frame(8'hC3, 1'b0, 1'b1);
    tests++; if (data_parll !== 11'h586 || rx_data !== 8'hC3 || parity_error !== 1'b0) begin
      fails++; $display("FAIL mid_next_frame got %h/%h/%b want 586/c3/0", data_parll, rx_data, parity_error);
    end
    do_handshake();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       par, stop;
    int         p0;
    for (int n = 0; n < 10; n++) begin
      d          = 8'($urandom_range(0, 255));
      par        = 1'($urandom_range(0, 1));
      stop       = ($urandom_range(0, 3) != 0);
      parity_odd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) do_handshake();
      p0 = pulse_cnt;
      send_frame(d, par, stop);
      model_frame(d, par, stop);
      tests++;
      if (pulse_cnt - p0 !== 1 || data_parll !== exp_parll || rx_data !== exp_data ||
          parity_error !== exp_pe || framing_error !== exp_fe ||
          rx_valid !== exp_valid || overrun !== exp_overrun) begin
        fails++;
        $display("FAIL rand_%0d got p%0d %h %h pe%b fe%b v%b o%b want p1 %h %h pe%b fe%b v%b o%b",
                 n, pulse_cnt - p0, data_parll, rx_data, parity_error, framing_error, rx_valid, overrun,
                 exp_parll, exp_data, exp_pe, exp_fe, exp_valid, exp_overrun);
      end
    end
    do_handshake();
    parity_odd = 1'b0;
  endtask

  task automatic test_pulse_width();
    tests++; if (wide_pulses !== 0) begin fails++; $display("FAIL pulse_width got %0d long pulses want 0", wide_pulses); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_framing_error();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    test_pulse_width();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
